// File: rtl/iommu_pkg.sv
// Shared IOMMU types: process context and PDTC controller state encoding.
package iommu_pkg;

    typedef struct packed {
        logic [19:0] pscid;
        logic [43:0] ppn;
        logic [3:0]  mode;
        logic        sum;
        logic        ens;
    } pc_t;

    typedef enum logic [1:0] {
        PDTC_IDLE      = 2'd0,
        PDTC_WALK_REQ  = 2'd1,
        PDTC_WALK_WAIT = 2'd2,
        PDTC_RESP      = 2'd3
    } pdtc_ctrl_state_e;

endpackage

// File: rtl/iommu_rr_arb.sv
// N-way round-robin arbiter; the pointer moves past the winner only on adv_i.
module iommu_rr_arb #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             adv_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] rr_q, rr_d;

    // First requesting slot at or after the pointer wins; idle slots are skipped
    always_comb begin
        int unsigned cand;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        rr_d        = rr_q;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= N) cand = cand - N;
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = IDX_W'(cand);
                gnt_valid_o = 1'b1;
                rr_d        = (cand + 1 >= N) ? '0 : IDX_W'(cand + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (adv_i && gnt_valid_o) begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/iommu_pdtc_ctrl.sv
// PDTC front end: arbitrates lookups, forwards flushes, runs one PDT walk on a
// miss and writes the result back unless a matching flush raced the walk.
//
// state          | meaning
// PDTC_IDLE      | accept flushes (priority) or grant one lookup
// PDTC_WALK_REQ  | walk_valid_o held until walker accepts
// PDTC_WALK_WAIT | waiting for walk_done_i
// PDTC_RESP      | response + optional cache update; flushes held off
module iommu_pdtc_ctrl
    import iommu_pkg::*;
#(
    parameter int unsigned N_REQ            = 2,
    parameter int unsigned DEVICE_ID_WIDTH  = 24,
    parameter int unsigned PROCESS_ID_WIDTH = 20,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [N_REQ-1:0]                        req_valid_i,
    output logic [N_REQ-1:0]                        req_ready_o,
    input  logic [N_REQ-1:0][DEVICE_ID_WIDTH-1:0]   req_did_i,
    input  logic [N_REQ-1:0][PROCESS_ID_WIDTH-1:0]  req_pid_i,
    output logic [N_REQ-1:0]                        rsp_valid_o,
    output logic                                    rsp_hit_o,
    output logic                                    rsp_fault_o,
    output pc_t                                     rsp_content_o,
    input  logic                                    flush_valid_i,
    output logic                                    flush_ready_o,
    input  logic                                    flush_dv_i,
    input  logic                                    flush_pv_i,
    input  logic [DEVICE_ID_WIDTH-1:0]              flush_did_i,
    input  logic [PROCESS_ID_WIDTH-1:0]             flush_pid_i,
    output logic                                    walk_valid_o,
    input  logic                                    walk_ready_i,
    output logic [DEVICE_ID_WIDTH-1:0]              walk_did_o,
    output logic [PROCESS_ID_WIDTH-1:0]             walk_pid_o,
    input  logic                                    walk_done_i,
    input  logic                                    walk_error_i,
    input  pc_t                                     walk_content_i,
    output logic                                    pdtc_flush_o,
    output logic                                    pdtc_flush_dv_o,
    output logic                                    pdtc_flush_pv_o,
    output logic [DEVICE_ID_WIDTH-1:0]              pdtc_flush_did_o,
    output logic [PROCESS_ID_WIDTH-1:0]             pdtc_flush_pid_o,
    output logic                                    pdtc_update_o,
    output logic [DEVICE_ID_WIDTH-1:0]              pdtc_up_did_o,
    output logic [PROCESS_ID_WIDTH-1:0]             pdtc_up_pid_o,
    output pc_t                                     pdtc_up_content_o,
    output logic                                    pdtc_lookup_o,
    output logic [DEVICE_ID_WIDTH-1:0]              pdtc_lu_did_o,
    output logic [PROCESS_ID_WIDTH-1:0]             pdtc_lu_pid_o,
    input  pc_t                                     pdtc_lu_content_i,
    input  logic                                    pdtc_lu_hit_i
);

    pdtc_ctrl_state_e              state_q, state_d;
    logic                          stale_q, stale_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DEVICE_ID_WIDTH-1:0]    did_q, did_d;
    logic [PROCESS_ID_WIDTH-1:0]   pid_q, pid_d;
    logic [N_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic                          rsp_hit_q, rsp_hit_d;
    logic                          rsp_fault_q, rsp_fault_d;
    pc_t                           rsp_content_q, rsp_content_d;
    logic                          walk_valid_q, walk_valid_d;
    logic                          update_q, update_d;

    logic [N_REQ-1:0] arb_req, gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             flush_hs;
    logic             stale_hit;

    // Lookups only compete in IDLE and only when no flush is pending
    assign arb_req = ((state_q == PDTC_IDLE) && !flush_valid_i) ? req_valid_i : '0;

    iommu_rr_arb #(.N(N_REQ)) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (arb_req),
        .adv_i       (gnt_valid),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Flushes are refused in RESP so they never collide with a cache update
    assign flush_hs = flush_valid_i && (state_q != PDTC_RESP);

    // A flush covering the in-flight walk tags makes its result uncacheable
    assign stale_hit = flush_hs &&
                       ((!flush_pv_i && !flush_dv_i) ||
                        (!flush_pv_i && flush_dv_i && (flush_did_i == did_q)) ||
                        (flush_pv_i && (flush_did_i == did_q) && (flush_pid_i == pid_q)));

    // Combinational lookup grant and zero-latency flush pass-through
    always_comb begin
        req_ready_o      = gnt;
        pdtc_lookup_o    = gnt_valid;
        pdtc_lu_did_o    = gnt_valid ? req_did_i[gnt_idx] : '0;
        pdtc_lu_pid_o    = gnt_valid ? req_pid_i[gnt_idx] : '0;
        flush_ready_o    = flush_hs;
        pdtc_flush_o     = flush_hs;
        pdtc_flush_dv_o  = flush_hs && flush_dv_i;
        pdtc_flush_pv_o  = flush_hs && flush_pv_i;
        pdtc_flush_did_o = flush_hs ? flush_did_i : '0;
        pdtc_flush_pid_o = flush_hs ? flush_pid_i : '0;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        stale_d       = stale_q;
        idx_d         = idx_q;
        did_d         = did_q;
        pid_d         = pid_q;
        rsp_valid_d   = '0;
        rsp_hit_d     = rsp_hit_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_content_d = rsp_content_q;
        walk_valid_d  = walk_valid_q;
        update_d      = 1'b0;
        unique case (state_q)
            PDTC_IDLE: begin
                if (gnt_valid) begin
                    idx_d = gnt_idx;
                    did_d = req_did_i[gnt_idx];
                    pid_d = req_pid_i[gnt_idx];
                    if (pdtc_lu_hit_i) begin
                        rsp_valid_d   = gnt;
                        rsp_hit_d     = 1'b1;
                        rsp_fault_d   = 1'b0;
                        rsp_content_d = pdtc_lu_content_i;
                    end else begin
                        walk_valid_d = 1'b1;
                        state_d      = PDTC_WALK_REQ;
                    end
                end
            end
            PDTC_WALK_REQ: begin
                if (stale_hit) stale_d = 1'b1;
                if (walk_ready_i) begin
                    walk_valid_d = 1'b0;
                    state_d      = PDTC_WALK_WAIT;
                end
            end
            PDTC_WALK_WAIT: begin
                if (stale_hit) stale_d = 1'b1;
                if (walk_done_i) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_hit_d          = 1'b0;
                    rsp_fault_d        = walk_error_i;
                    rsp_content_d      = walk_content_i;
                    update_d           = !walk_error_i && !(stale_q || stale_hit);
                    state_d            = PDTC_RESP;
                end
            end
            PDTC_RESP: begin
                stale_d = 1'b0;
                state_d = PDTC_IDLE;
            end
            default: state_d = PDTC_IDLE;
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= PDTC_IDLE;
            stale_q       <= 1'b0;
            idx_q         <= '0;
            did_q         <= '0;
            pid_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_content_q <= '0;
            walk_valid_q  <= 1'b0;
            update_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            stale_q       <= stale_d;
            idx_q         <= idx_d;
            did_q         <= did_d;
            pid_q         <= pid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_content_q <= rsp_content_d;
            walk_valid_q  <= walk_valid_d;
            update_q      <= update_d;
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_hit_o         = rsp_hit_q;
    assign rsp_fault_o       = rsp_fault_q;
    assign rsp_content_o     = rsp_content_q;
    assign walk_valid_o      = walk_valid_q;
    assign walk_did_o        = did_q;
    assign walk_pid_o        = pid_q;
    assign pdtc_update_o     = update_q;
    assign pdtc_up_did_o     = did_q;
    assign pdtc_up_pid_o     = pid_q;
    assign pdtc_up_content_o = rsp_content_q;

endmodule

// File: tb/tb_iommu_pdtc_ctrl.sv
// Self-checking bench: a transaction-level model with its own PDTC contents
// predicts every output each cycle; directed cases pin literal values.
module tb_iommu_pdtc_ctrl;
    import iommu_pkg::*;

    localparam int N  = 2;
    localparam int DW = 24;
    localparam int PW = 20;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [N-1:0] req_valid_i, req_ready_o, rsp_valid_o;
    logic [N-1:0][DW-1:0] req_did_i;
    logic [N-1:0][PW-1:0] req_pid_i;
    logic rsp_hit_o, rsp_fault_o;
    pc_t rsp_content_o;
    logic flush_valid_i, flush_ready_o, flush_dv_i, flush_pv_i;
    logic [DW-1:0] flush_did_i;
    logic [PW-1:0] flush_pid_i;
    logic walk_valid_o, walk_ready_i, walk_done_i, walk_error_i;
    logic [DW-1:0] walk_did_o;
    logic [PW-1:0] walk_pid_o;
    pc_t walk_content_i;
    logic pdtc_flush_o, pdtc_flush_dv_o, pdtc_flush_pv_o;
    logic [DW-1:0] pdtc_flush_did_o, pdtc_up_did_o, pdtc_lu_did_o;
    logic [PW-1:0] pdtc_flush_pid_o, pdtc_up_pid_o, pdtc_lu_pid_o;
    logic pdtc_update_o, pdtc_lookup_o, pdtc_lu_hit_i;
    pc_t pdtc_up_content_o, pdtc_lu_content_i;

    always #5 clk_i = ~clk_i;

    iommu_pdtc_ctrl #(.N_REQ(N), .DEVICE_ID_WIDTH(DW), .PROCESS_ID_WIDTH(PW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_did_i(req_did_i), .req_pid_i(req_pid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_fault_o(rsp_fault_o),
        .rsp_content_o(rsp_content_o),
        .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
        .flush_dv_i(flush_dv_i), .flush_pv_i(flush_pv_i),
        .flush_did_i(flush_did_i), .flush_pid_i(flush_pid_i),
        .walk_valid_o(walk_valid_o), .walk_ready_i(walk_ready_i),
        .walk_did_o(walk_did_o), .walk_pid_o(walk_pid_o),
        .walk_done_i(walk_done_i), .walk_error_i(walk_error_i), .walk_content_i(walk_content_i),
        .pdtc_flush_o(pdtc_flush_o), .pdtc_flush_dv_o(pdtc_flush_dv_o), .pdtc_flush_pv_o(pdtc_flush_pv_o),
        .pdtc_flush_did_o(pdtc_flush_did_o), .pdtc_flush_pid_o(pdtc_flush_pid_o),
        .pdtc_update_o(pdtc_update_o), .pdtc_up_did_o(pdtc_up_did_o), .pdtc_up_pid_o(pdtc_up_pid_o),
        .pdtc_up_content_o(pdtc_up_content_o),
        .pdtc_lookup_o(pdtc_lookup_o), .pdtc_lu_did_o(pdtc_lu_did_o), .pdtc_lu_pid_o(pdtc_lu_pid_o),
        .pdtc_lu_content_i(pdtc_lu_content_i), .pdtc_lu_hit_i(pdtc_lu_hit_i)
    );

    int checks = 0;
    int errors = 0;

    // Model: PDTC contents keyed by {did,pid}, plus transaction bookkeeping
    pc_t cache [logic [43:0]];
    int  m_mode;        // 0 free, 1 walk asked, 2 walk running, 3 answering
    int  m_rr, m_idx, g;
    bit  m_stale, f_ok;
    logic [DW-1:0] m_did;
    logic [PW-1:0] m_pid;
    logic [N-1:0] e_rsp_valid;
    bit  e_hit, e_fault, e_walk_valid, e_update;
    pc_t e_content;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] key(logic [DW-1:0] d, logic [PW-1:0] p);
        return {d, p};
    endfunction

    function automatic bit flush_hits(bit dv, bit pv, logic [DW-1:0] fd, logic [PW-1:0] fp,
                                      logic [DW-1:0] d, logic [PW-1:0] p);
        if (!dv && !pv) return 1'b1;
        if (!pv) return fd == d;
        return (fd == d) && (fp == p);
    endfunction

    function automatic pc_t rand_pc();
        pc_t p;
        p.pscid = 20'($urandom);
        p.ppn   = {12'($urandom), $urandom};
        p.mode  = 4'($urandom);
        p.sum   = 1'($urandom);
        p.ens   = 1'($urandom);
        return p;
    endfunction

    task automatic clear_inputs();
        req_valid_i = '0; req_did_i = '0; req_pid_i = '0;
        flush_valid_i = 0; flush_dv_i = 0; flush_pv_i = 0; flush_did_i = '0; flush_pid_i = '0;
        walk_ready_i = 0; walk_done_i = 0; walk_error_i = 0; walk_content_i = '0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_rr = 0; m_idx = 0; m_stale = 0; m_did = '0; m_pid = '0;
        e_rsp_valid = '0; e_hit = 0; e_fault = 0; e_walk_valid = 0; e_update = 0; e_content = '0;
    endtask

    // Predict this cycle's combinational outputs, act as the PDTC, compare
    task automatic settle();
        logic [N-1:0] oh;
        f_ok = flush_valid_i && (m_mode != 3);
        g = -1;
        if (m_mode == 0 && !flush_valid_i)
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (g < 0 && req_valid_i[j]) g = j;
            end
        if (g >= 0 && cache.exists(key(req_did_i[g], req_pid_i[g]))) begin
            pdtc_lu_hit_i = 1'b1;
            pdtc_lu_content_i = cache[key(req_did_i[g], req_pid_i[g])];
        end else begin
            pdtc_lu_hit_i = 1'b0;
            pdtc_lu_content_i = rand_pc();
        end
        #1;
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("req_ready", req_ready_o, oh);
        chk("pdtc_lookup", pdtc_lookup_o, g >= 0);
        if (g >= 0) begin
            chk("lu_did", pdtc_lu_did_o, req_did_i[g]);
            chk("lu_pid", pdtc_lu_pid_o, req_pid_i[g]);
        end
        chk("flush_ready", flush_ready_o, f_ok);
        chk("pdtc_flush", pdtc_flush_o, f_ok);
        if (f_ok) begin
            chk("pdtc_flush_dv", pdtc_flush_dv_o, flush_dv_i);
            chk("pdtc_flush_pv", pdtc_flush_pv_o, flush_pv_i);
            chk("pdtc_flush_did", pdtc_flush_did_o, flush_did_i);
            chk("pdtc_flush_pid", pdtc_flush_pid_o, flush_pid_i);
        end
    endtask

    // Advance the model over one clock edge and compare registered outputs
    task automatic clock();
        logic [43:0] victims[$];
        e_rsp_valid = '0;
        e_update = 0;
        if (f_ok) begin
            if ((m_mode == 1 || m_mode == 2) &&
                flush_hits(flush_dv_i, flush_pv_i, flush_did_i, flush_pid_i, m_did, m_pid))
                m_stale = 1;
            foreach (cache[k])
                if (flush_hits(flush_dv_i, flush_pv_i, flush_did_i, flush_pid_i, k[43:20], k[19:0]))
                    victims.push_back(k);
            foreach (victims[i]) cache.delete(victims[i]);
        end
        case (m_mode)
            0: if (g >= 0) begin
                m_rr = (g + 1) % N; m_idx = g;
                m_did = req_did_i[g]; m_pid = req_pid_i[g];
                if (pdtc_lu_hit_i) begin
                    e_rsp_valid[g] = 1'b1; e_hit = 1; e_fault = 0; e_content = pdtc_lu_content_i;
                end else begin
                    m_mode = 1; e_walk_valid = 1;
                end
            end
            1: if (walk_ready_i) begin m_mode = 2; e_walk_valid = 0; end
            2: if (walk_done_i) begin
                e_rsp_valid[m_idx] = 1'b1; e_hit = 0; e_fault = walk_error_i;
                e_content = walk_content_i;
                e_update = !walk_error_i && !m_stale;
                m_mode = 3;
            end
            default: begin m_stale = 0; m_mode = 0; end
        endcase
        @(posedge clk_i);
        #1;
        if (e_update) cache[key(m_did, m_pid)] = e_content;
        chk("rsp_valid", rsp_valid_o, e_rsp_valid);
        chk("walk_valid", walk_valid_o, e_walk_valid);
        chk("pdtc_update", pdtc_update_o, e_update);
        if (e_walk_valid) begin
            chk("walk_did", walk_did_o, m_did);
            chk("walk_pid", walk_pid_o, m_pid);
        end
        if (e_rsp_valid != '0) begin
            chk("rsp_hit", rsp_hit_o, e_hit);
            chk("rsp_fault", rsp_fault_o, e_fault);
            chk("rsp_content", rsp_content_o, e_content);
        end
        if (e_update) begin
            chk("up_did", pdtc_up_did_o, m_did);
            chk("up_pid", pdtc_up_pid_o, m_pid);
            chk("up_content", pdtc_up_content_o, e_content);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        #1;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_hit", rsp_hit_o, 0);
        chk("rst_rsp_fault", rsp_fault_o, 0);
        chk("rst_rsp_content", rsp_content_o, 0);
        chk("rst_walk_valid", walk_valid_o, 0);
        chk("rst_update", pdtc_update_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_flush_ready", flush_ready_o, 0);
        chk("rst_lookup", pdtc_lookup_o, 0);
        chk("rst_pdtc_flush", pdtc_flush_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        rst_ni = 1'b1;
    endtask

    // One miss transaction with literal checks; optional flush during the walk
    task automatic run_miss(int idx, logic [DW-1:0] d, logic [PW-1:0] p,
                            bit do_flush, logic [PW-1:0] fpid, bit err, int exp_upd);
        pc_t c;
        int n_upd;
        logic [N-1:0] oh;
        oh = '0; oh[idx] = 1'b1;
        clear_inputs();
        req_valid_i[idx] = 1; req_did_i[idx] = d; req_pid_i[idx] = p;
        settle(); clock(); clear_inputs();
        chk("miss_walk_valid", walk_valid_o, 1);
        chk("miss_walk_did", walk_did_o, d);
        chk("miss_walk_pid", walk_pid_o, p);
        walk_done_i = 1; walk_content_i = rand_pc();
        settle(); clock(); clear_inputs();
        chk("early_done_ignored", rsp_valid_o, 0);
        walk_ready_i = 1;
        settle(); clock(); clear_inputs();
        if (do_flush) begin
            flush_valid_i = 1; flush_pv_i = 1; flush_dv_i = 1; flush_did_i = d; flush_pid_i = fpid;
            settle();
            chk("race_flush_ready", flush_ready_o, 1);
            clock(); clear_inputs();
        end
        c = rand_pc();
        walk_done_i = 1; walk_error_i = err; walk_content_i = c;
        settle(); clock(); clear_inputs();
        chk("miss_rsp_valid", rsp_valid_o, oh);
        chk("miss_rsp_hit", rsp_hit_o, 0);
        chk("miss_rsp_fault", rsp_fault_o, err);
        chk("miss_rsp_content", rsp_content_o, c);
        n_upd = int'(pdtc_update_o);
        settle(); clock();
        n_upd += int'(pdtc_update_o);
        chk("miss_update_count", n_upd, exp_upd);
    endtask

    initial begin
        pc_t pc_a;
        clear_inputs();
        pdtc_lu_hit_i = 0; pdtc_lu_content_i = '0;
        model_reset();
        do_reset();

        // Hit on a preloaded entry
        pc_a = rand_pc();
        cache[key(24'h12, 20'h5)] = pc_a;
        req_valid_i = 2'b01; req_did_i[0] = 24'h12; req_pid_i[0] = 20'h5;
        settle();
        chk("hit_ready", req_ready_o, 2'b01);
        clock(); clear_inputs();
        chk("hit_rsp_valid", rsp_valid_o, 2'b01);
        chk("hit_flag", rsp_hit_o, 1);
        chk("hit_content", rsp_content_o, pc_a);

        // Miss, walk, update, then the repeat lookup hits
        run_miss(1, 24'h3, 20'h7, 0, '0, 0, 1);
        req_valid_i = 2'b10; req_did_i[1] = 24'h3; req_pid_i[1] = 20'h7;
        settle(); clock(); clear_inputs();
        chk("rehit_rsp_valid", rsp_valid_o, 2'b10);
        chk("rehit_flag", rsp_hit_o, 1);

        // Evict 3/7, then race a matching and a non-matching flush against walks
        flush_valid_i = 1; flush_pv_i = 1; flush_dv_i = 1; flush_did_i = 24'h3; flush_pid_i = 20'h7;
        settle(); clock(); clear_inputs();
        run_miss(0, 24'h3, 20'h7, 1, 20'h7, 0, 0);
        run_miss(1, 24'h3, 20'h7, 1, 20'h8, 0, 1);

        // Two always-valid requesters alternate; a flush blocks the grant
        for (int k = 0; k < 6; k++) begin
            req_valid_i = 2'b11;
            req_did_i[0] = 24'h12; req_pid_i[0] = 20'h5;
            req_did_i[1] = 24'h3;  req_pid_i[1] = 20'h7;
            settle();
            chk("arb_grant", req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            clock();
        end
        flush_valid_i = 1; flush_dv_i = 1; flush_pv_i = 1; flush_did_i = 24'h77; flush_pid_i = '0;
        settle();
        chk("flush_blocks_grant", req_ready_o, 2'b00);
        chk("flush_zero_latency", pdtc_flush_o, 1);
        clock();
        flush_valid_i = 0;
        settle();
        chk("grant_after_flush", req_ready_o, 2'b01);
        clock(); clear_inputs();

        // Walk error: fault reported, nothing cached
        run_miss(0, 24'h44, 20'h9, 0, '0, 1, 0);

        // Reset while the walk is outstanding
        req_valid_i = 2'b10; req_did_i[1] = 24'h55; req_pid_i[1] = 20'h1;
        settle(); clock(); clear_inputs();
        walk_ready_i = 1;
        settle(); clock(); clear_inputs();
        do_reset();
        req_valid_i = 2'b11;
        settle();
        chk("post_reset_grant", req_ready_o, 2'b01);
        clock(); clear_inputs();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid_i = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_did_i[i] = DW'($urandom_range(0, 3));
                req_pid_i[i] = PW'($urandom_range(0, 3));
            end
            flush_valid_i = ($urandom % 6) == 0;
            flush_dv_i = 1'($urandom);
            flush_pv_i = 1'($urandom);
            flush_did_i = DW'($urandom_range(0, 3));
            flush_pid_i = PW'($urandom_range(0, 3));
            walk_ready_i = 1'($urandom);
            walk_done_i = ($urandom % 3) == 0;
            walk_error_i = ($urandom % 4) == 0;
            walk_content_i = rand_pc();
            settle();
            clock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
